btn_conditioner: RTL

- Front-end conditioner for one mechanical push-button.
- Pipeline: 2-FF synchroniser, counter-based debounce filter, then edge detection.
- Outputs a clean stable level plus single-cycle press and release strobes.
- Sits directly upstream of the register/counter load logic and drives its load-enable (press strobe).

---
 rtl/btn_conditioner.sv | 126 ++++++++++++
 1 files changed

// File: rtl/btn_conditioner.sv
// Push-button front end: 2-FF synchroniser, counter debounce, registered press/release strobes.
// Define BTN_AUTOREPEAT_EN to add auto-repeat of the press strobe while the button is held.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic bt_i,
  output logic btn_o,
  output logic btnd_o,
  output logic btnu_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] db_cnt;
  logic [CW-1:0] db_cnt_next;
  logic          flip;
  logic          btn_next;
  logic          press_next;
  logic          release_next;
  logic          rep_next;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= bt_i;
      s2 <= s1;
    end
  end

  // The level flips only after s2 has disagreed with it for DEBOUNCE_CYCLES cycles in a row.
  always_comb begin
    flip         = (s2 != btn_o) && (db_cnt == DB_LAST);
    btn_next     = flip ? s2 : btn_o;
    press_next   = flip & s2;
    release_next = flip & ~s2;
    db_cnt_next  = ((s2 == btn_o) || flip) ? '0 : db_cnt + CW'(1);
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_state_t;

  rep_state_t    state;
  rep_state_t    state_next;
  logic [RW-1:0] rep_cnt;
  logic [RW-1:0] rep_cnt_next;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      rep_cnt <= '0;
    end else begin
      state   <= state_next;
      rep_cnt <= rep_cnt_next;
    end
  end

  // Repeat strobe is decided one cycle ahead from next-state values so btnd_o stays registered.
  always_comb begin
    state_next   = state;
    rep_cnt_next = rep_cnt;
    rep_next     = 1'b0;
    if (btnu_o) begin
      state_next   = IDLE;
      rep_cnt_next = '0;
    end else begin
      case (state)
        IDLE: begin
          rep_cnt_next = '0;
          if (btnd_o) state_next = DELAY;
        end
        DELAY: begin
          if (rep_cnt == DELAY_LAST) begin
            state_next   = REPEAT;
            rep_cnt_next = '0;
          end else begin
            rep_cnt_next = rep_cnt + RW'(1);
          end
        end
        REPEAT: begin
          if (rep_cnt == PERIOD_LAST) rep_cnt_next = '0;
          else                        rep_cnt_next = rep_cnt + RW'(1);
        end
        default: begin
          state_next   = IDLE;
          rep_cnt_next = '0;
        end
      endcase
    end
    rep_next = btn_next &&
               (((state_next == DELAY)  && (rep_cnt_next == DELAY_LAST)) ||
                ((state_next == REPEAT) && (rep_cnt_next == PERIOD_LAST)));
  end
`else
  // Repeat timing only matters with the feature; kept referenced so both builds share one interface.
  assign rep_next = (REPEAT_DELAY < 1) && (REPEAT_PERIOD < 1);
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      db_cnt <= '0;
      btn_o  <= 1'b0;
      btnd_o <= 1'b0;
      btnu_o <= 1'b0;
    end else begin
      db_cnt <= db_cnt_next;
      btn_o  <= btn_next;
      btnd_o <= press_next | rep_next;
      btnu_o <= release_next;
    end
  end

endmodule
